fizzbuzz_text_tx: RTL

FIZZBUZZ_TEXT_TX -- requirements
Module: fizzbuzz_text_tx

---
 rtl/fizzbuzz_pkg.sv | 47 ++++
 rtl/fizzbuzz_text_tx_if.sv | 26 ++
 rtl/fizzbuzz_bin2bcd.sv | 25 ++
 rtl/fizzbuzz_text_tx_core.sv | 129 ++++++++++++
 rtl/fizzbuzz_text_tx.sv | 40 ++++
 5 files changed

// File: rtl/fizzbuzz_pkg.sv
// Shared types and constants for the FizzBuzz text transmitter: line FSM states,
// ASCII codes, the "FizzBuzz" character ROM and the flag-consistency reference.
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WORD,
        S_DIGITS,
        S_NEWLINE
    } state_t;

    typedef struct packed {
        logic fizzbuzz;
        logic fizz;
        logic buzz;
    } flags_t;

    localparam logic [7:0] ASCII_NL   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // "Fizz" and "Buzz" are the two halves of the "FizzBuzz" ROM.
    localparam logic [2:0] FIZZ_FIRST = 3'd0;
    localparam logic [2:0] FIZZ_LAST  = 3'd3;
    localparam logic [2:0] BUZZ_FIRST = 3'd4;
    localparam logic [2:0] BUZZ_LAST  = 3'd7;

    function automatic logic [7:0] word_rom(input logic [2:0] idx);
        logic [7:0] ch;
        unique case (idx)
            3'd0:    ch = 8'h46;  // F
            3'd1:    ch = 8'h69;  // i
            3'd4:    ch = 8'h42;  // B
            3'd5:    ch = 8'h75;  // u
            default: ch = 8'h7A;  // z
        endcase
        return ch;
    endfunction

    function automatic flags_t expected_flags(input logic [7:0] value);
        flags_t f;
        f.fizzbuzz = (value % 8'd15) == 8'd0;
        f.fizz     = ((value % 8'd3) == 8'd0) && !f.fizzbuzz;
        f.buzz     = ((value % 8'd5) == 8'd0) && !f.fizzbuzz;
        return f;
    endfunction

endpackage

// File: rtl/fizzbuzz_text_tx_if.sv
// Result-in / byte-out stream bundle of the FizzBuzz text transmitter.
interface fizzbuzz_text_tx_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_value;
    logic       in_fizz;
    logic       in_buzz;
    logic       in_fizzbuzz;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       err;

    modport master (
        output in_valid, in_value, in_fizz, in_buzz, in_fizzbuzz, out_ready,
        input  in_ready, out_valid, out_data, out_last, err
    );

    modport slave (
        input  in_valid, in_value, in_fizz, in_buzz, in_fizzbuzz, out_ready,
        output in_ready, out_valid, out_data, out_last, err
    );

endinterface

// File: rtl/fizzbuzz_bin2bcd.sv
// Combinational 8-bit binary to three-digit BCD converter (shift-and-add-3).
module fizzbuzz_bin2bcd (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units
);

    logic [19:0] shift;

    always_comb begin
        shift = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (shift[11:8]  >= 4'd5) shift[11:8]  = shift[11:8]  + 4'd3;
            if (shift[15:12] >= 4'd5) shift[15:12] = shift[15:12] + 4'd3;
            if (shift[19:16] >= 4'd5) shift[19:16] = shift[19:16] + 4'd3;
            shift = shift << 1;
        end
    end

    assign hundreds = shift[19:16];
    assign tens     = shift[15:12];
    assign units    = shift[11:8];

endmodule

// File: rtl/fizzbuzz_text_tx_core.sv
// Line FSM: takes one FizzBuzz result in IDLE and streams its word or decimal
// digits followed by a newline, flagging inconsistent input flags.
module fizzbuzz_text_tx_core (
    input  logic                clk,
    input  logic                reset,
    fizzbuzz_text_tx_if.slave   bus
);

    import fizzbuzz_pkg::*;

    state_t     state_q, state_d;
    logic [2:0] char_q, char_d;
    logic [2:0] char_end_q, char_end_d;
    logic [1:0] dig_q, dig_d;
    logic [3:0] hun_q, hun_d;
    logic [3:0] ten_q, ten_d;
    logic [3:0] unit_q, unit_d;
    logic       err_q, err_d;

    logic [3:0] bcd_h, bcd_t, bcd_u;
    logic [3:0] digit;
    flags_t     in_flags;

    assign in_flags = {bus.in_fizzbuzz, bus.in_fizz, bus.in_buzz};

    // Digits are captured at acceptance so later in_value changes are ignored.
    fizzbuzz_bin2bcd u_bin2bcd (
        .bin      (bus.in_value),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .units    (bcd_u)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        char_d        = char_q;
        char_end_d    = char_end_q;
        dig_d         = dig_q;
        hun_d         = hun_q;
        ten_d         = ten_q;
        unit_d        = unit_q;
        err_d         = err_q;
        digit         = unit_q;
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q != S_IDLE);
        bus.out_data  = 8'h00;
        bus.out_last  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    hun_d  = bcd_h;
                    ten_d  = bcd_t;
                    unit_d = bcd_u;
                    err_d  = err_q | (in_flags != expected_flags(bus.in_value));
                    if (in_flags.fizzbuzz) begin
                        state_d    = S_WORD;
                        char_d     = FIZZ_FIRST;
                        char_end_d = BUZZ_LAST;
                    end else if (in_flags.fizz) begin
                        state_d    = S_WORD;
                        char_d     = FIZZ_FIRST;
                        char_end_d = FIZZ_LAST;
                    end else if (in_flags.buzz) begin
                        state_d    = S_WORD;
                        char_d     = BUZZ_FIRST;
                        char_end_d = BUZZ_LAST;
                    end else begin
                        // Skip leading zeros; a zero value still emits its units digit.
                        state_d = S_DIGITS;
                        dig_d   = (bcd_h != 4'd0) ? 2'd0 : (bcd_t != 4'd0) ? 2'd1 : 2'd2;
                    end
                end
            end
            S_WORD: begin
                bus.out_data = word_rom(char_q);
                if (bus.out_ready) begin
                    if (char_q == char_end_q) state_d = S_NEWLINE;
                    else                      char_d  = char_q + 3'd1;
                end
            end
            S_DIGITS: begin
                unique case (dig_q)
                    2'd0:    digit = hun_q;
                    2'd1:    digit = ten_q;
                    default: digit = unit_q;
                endcase
                bus.out_data = ASCII_ZERO | {4'd0, digit};
                if (bus.out_ready) begin
                    if (dig_q == 2'd2) state_d = S_NEWLINE;
                    else               dig_d   = dig_q + 2'd1;
                end
            end
            S_NEWLINE: begin
                bus.out_data = ASCII_NL;
                bus.out_last = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.err = err_q;

    // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            char_q     <= '0;
            char_end_q <= '0;
            dig_q      <= '0;
            hun_q      <= '0;
            ten_q      <= '0;
            unit_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_q     <= char_d;
            char_end_q <= char_end_d;
            dig_q      <= dig_d;
            hun_q      <= hun_d;
            ten_q      <= ten_d;
            unit_q     <= unit_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: rtl/fizzbuzz_text_tx.sv
// Top level of the FizzBuzz text transmitter: flat ports bundled onto the
// stream interface that feeds the line FSM.
module fizzbuzz_text_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_value,
    input  logic       in_fizz,
    input  logic       in_buzz,
    input  logic       in_fizzbuzz,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       err
);

    fizzbuzz_text_tx_if u_bus ();

    assign u_bus.in_valid    = in_valid;
    assign u_bus.in_value    = in_value;
    assign u_bus.in_fizz     = in_fizz;
    assign u_bus.in_buzz     = in_buzz;
    assign u_bus.in_fizzbuzz = in_fizzbuzz;
    assign u_bus.out_ready   = out_ready;

    assign in_ready  = u_bus.in_ready;
    assign out_valid = u_bus.out_valid;
    assign out_data  = u_bus.out_data;
    assign out_last  = u_bus.out_last;
    assign err       = u_bus.err;

    fizzbuzz_text_tx_core u_core (
        .clk   (clk),
        .reset (reset),
        .bus   (u_bus)
    );

endmodule
